// File: rtl/wave_manager_if.sv
// Stage-play handshake between flow FSM, enemy engine and wave manager.
// The slave view belongs to the wave manager; master is the surrounding game.
interface wave_manager_if;
  logic       stage_1_in_progress;
  logic       stage_2_in_progress;
  logic       stage_3_in_progress;
  logic       frame_tick;
  logic       spawn_ack;
  logic       enemy_killed;
  logic       enemy_escaped;
  logic       spawn_req;
  logic [1:0] spawn_stage;
  logic [4:0] enemies_remaining;
  logic [2:0] lives;
  logic       stage_1_done;
  logic       stage_2_done;
  logic       stage_3_done;
  logic       game_over;

  modport master (
    output stage_1_in_progress, stage_2_in_progress,
    output stage_3_in_progress, frame_tick, spawn_ack,
    output enemy_killed, enemy_escaped,
    input  spawn_req, spawn_stage, enemies_remaining,
    input  lives, stage_1_done, stage_2_done,
    input  stage_3_done, game_over
  );

  modport slave (
    input  stage_1_in_progress, stage_2_in_progress,
    input  stage_3_in_progress, frame_tick, spawn_ack,
    input  enemy_killed, enemy_escaped,
    output spawn_req, spawn_stage, enemies_remaining,
    output lives, stage_1_done, stage_2_done,
    output stage_3_done, game_over
  );
endinterface

// File: rtl/wave_manager.sv
// Per-stage enemy wave sequencer, kill/escape tally and life tracking.
// Optional BONUS_LIFE_EN: one life restored (capped) on each stage clear.
module wave_manager #(
  parameter int unsigned S1_ENEMIES     = 8,
  parameter int unsigned S2_ENEMIES     = 12,
  parameter int unsigned S3_ENEMIES     = 16,
  parameter int unsigned SPAWN_INTERVAL = 60,
  parameter int unsigned START_LIVES    = 5
) (
  input logic           clk,
  input logic           reset,
  wave_manager_if.slave bus
);

  localparam logic [4:0] N1     = 5'(S1_ENEMIES);
  localparam logic [4:0] N2     = 5'(S2_ENEMIES);
  localparam logic [4:0] N3     = 5'(S3_ENEMIES);
  localparam logic [7:0] IVL    = 8'(SPAWN_INTERVAL);
  localparam logic [2:0] LIVES0 = 3'(START_LIVES);

`ifdef BONUS_LIFE_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD, REQ, WAIT, DRAIN, DONE, DEAD
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [4:0] left_q, left_d;
  logic [4:0] alive_q, alive_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] lives_q, lives_d;
  logic [4:0] rem_q, rem_d;

  logic [2:0] ip;
  logic       ip_cur;
  logic [1:0] sel;
  logic [4:0] sel_n;
  logic       active;
  logic       ack;
  logic       esc;
  logic       kil;
  logic [4:0] alive_n;
  logic [2:0] lives_n;

  assign ip = {bus.stage_3_in_progress,
               bus.stage_2_in_progress,
               bus.stage_1_in_progress};

  assign active = state_q inside {LOAD, REQ, WAIT, DRAIN};
  assign ack    = (state_q == REQ) && bus.spawn_ack;

  // Escapes claim an alive enemy first so a life is never lost silently.
  assign esc = active && bus.enemy_escaped && (alive_q != 5'd0);
  assign kil = active && bus.enemy_killed
               && (alive_q > {4'd0, esc});

  assign alive_n = alive_q + {4'd0, ack}
                   - {4'd0, esc} - {4'd0, kil};
  assign lives_n = lives_q
                   - {2'd0, esc && (lives_q != 3'd0)};

  always_comb begin
    sel   = 2'd0;
    sel_n = 5'd0;
    priority case (1'b1)
      ip[0]: begin sel = 2'd1; sel_n = N1; end
      ip[1]: begin sel = 2'd2; sel_n = N2; end
      ip[2]: begin sel = 2'd3; sel_n = N3; end
      default: ;
    endcase
  end

  always_comb begin
    ip_cur = 1'b0;
    case (stage_q)
      2'd1:    ip_cur = ip[0];
      2'd2:    ip_cur = ip[1];
      2'd3:    ip_cur = ip[2];
      default: ip_cur = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    left_d  = left_q;
    alive_d = alive_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;

    if (active) begin
      alive_d = alive_n;
      lives_d = lives_n;
    end

    case (state_q)
      IDLE: begin
        if (|ip) begin
          state_d = LOAD;
          stage_d = sel;
          left_d  = sel_n;
          alive_d = 5'd0;
          cnt_d   = 8'd0;
        end
      end
      LOAD: state_d = REQ;
      REQ: begin
        if (bus.spawn_ack) begin
          left_d  = left_q - 5'd1;
          cnt_d   = 8'd0;
          state_d = (left_q > 5'd1) ? WAIT : DRAIN;
        end
      end
      WAIT: begin
        if (bus.frame_tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == IVL) state_d = REQ;
        end
      end
      DRAIN: begin
        if (alive_q == 5'd0) begin
          state_d = DONE;
          if (BONUS && (lives_q < LIVES0))
            lives_d = lives_q + 3'd1;
        end
      end
      DONE: if (!(|ip)) state_d = IDLE;
      DEAD: state_d = DEAD;
      default: state_d = IDLE;
    endcase

    // Death outranks an abort, which outranks normal sequencing.
    if (active && !ip_cur) begin
      state_d = IDLE;
      left_d  = 5'd0;
      alive_d = 5'd0;
      cnt_d   = 8'd0;
    end
    if (active && (lives_q == 3'd0)) state_d = DEAD;
  end

  assign rem_d = left_d + alive_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= 2'd0;
      left_q  <= 5'd0;
      alive_q <= 5'd0;
      cnt_q   <= 8'd0;
      lives_q <= LIVES0;
      rem_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      left_q  <= left_d;
      alive_q <= alive_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.spawn_req         = (state_q == REQ);
  assign bus.spawn_stage       = (state_q == REQ) ? stage_q : 2'd0;
  assign bus.enemies_remaining = rem_q;
  assign bus.lives             = lives_q;
  assign bus.stage_1_done      = (state_q == DONE) && (stage_q == 2'd1);
  assign bus.stage_2_done      = (state_q == DONE) && (stage_q == 2'd2);
  assign bus.stage_3_done      = (state_q == DONE) && (stage_q == 2'd3);
  assign bus.game_over         = (state_q == DEAD);

endmodule

// File: tb/tb_wave_manager.sv
// Directed bench for wave_manager with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wave_manager;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wave_manager_if bus();

  wave_manager dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic wait_req(input int want);
    int  ticks = 0;
    int  n = 0;
    bit  tog = 1'b0;
    while (bus.spawn_req !== 1'b1 && n < 1000) begin
      tog = ~tog;
      bus.frame_tick = tog;
      if (tog) ticks++;
      @(negedge clk);
      n++;
    end
    bus.frame_tick = 1'b0;
    checks++;
    if (ticks != want) begin
      fails++;
      $display("FAIL req_interval: got %0d ticks, want %0d", ticks, want);
    end
  endtask

  task automatic do_ack();
    bus.spawn_ack = 1'b1;
    @(negedge clk);
    bus.spawn_ack = 1'b0;
  endtask

  task automatic pulse(input bit k, input bit e);
    bus.enemy_killed  = k;
    bus.enemy_escaped = e;
    @(negedge clk);
    bus.enemy_killed  = 1'b0;
    bus.enemy_escaped = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.spawn_req !== 1'b0 || bus.spawn_stage !== 2'd0) begin
      fails++;
      $display("FAIL reset_req: got req=%0b stage=%0d, want 0/0",
               bus.spawn_req, bus.spawn_stage);
    end
    checks++;
    if (bus.enemies_remaining !== 5'd0 || bus.lives !== 3'd5) begin
      fails++;
      $display("FAIL reset_cnt: got rem=%0d lives=%0d, want 0/5",
               bus.enemies_remaining, bus.lives);
    end
    checks++;
    if ({bus.stage_1_done, bus.stage_2_done, bus.stage_3_done,
         bus.game_over} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b, want 0000",
               {bus.stage_1_done, bus.stage_2_done,
                bus.stage_3_done, bus.game_over});
    end
    reset = 1'b0;
  endtask

  task automatic test_stage1();
    bus.stage_1_in_progress = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.enemies_remaining !== 5'd8 || bus.spawn_req !== 1'b0) begin
      fails++;
      $display("FAIL s1_load: got rem=%0d req=%0b, want 8/0",
               bus.enemies_remaining, bus.spawn_req);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) wait_req(60);
      checks++;
      if (bus.spawn_req !== 1'b1 || bus.spawn_stage !== 2'd1) begin
        fails++;
        $display("FAIL s1_req%0d: got req=%0b stage=%0d, want 1/1",
                 i, bus.spawn_req, bus.spawn_stage);
      end
      do_ack();
      checks++;
      if (bus.spawn_req !== 1'b0 || bus.enemies_remaining !== 5'd8) begin
        fails++;
        $display("FAIL s1_ack%0d: got req=%0b rem=%0d, want 0/8",
                 i, bus.spawn_req, bus.enemies_remaining);
      end
    end
    for (int j = 0; j < 8; j++) begin
      pulse(1'b1, 1'b0);
      checks++;
      if (bus.enemies_remaining !== 5'(7 - j)) begin
        fails++;
        $display("FAIL s1_kill%0d: got rem=%0d, want %0d",
                 j, bus.enemies_remaining, 7 - j);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.stage_1_done, bus.stage_2_done, bus.stage_3_done}
        !== 3'b100 || bus.lives !== 3'd5) begin
      fails++;
      $display("FAIL s1_done: got done=%b lives=%0d, want 100/5",
               {bus.stage_1_done, bus.stage_2_done, bus.stage_3_done},
               bus.lives);
    end
    bus.stage_1_in_progress = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stage_1_done !== 1'b0) begin
      fails++;
      $display("FAIL s1_idle: got done=%0b, want 0", bus.stage_1_done);
    end
  endtask

  task automatic test_backpressure();
    bit tog = 1'b0;
    bus.stage_1_in_progress = 1'b1;
    repeat (2) @(negedge clk);
    do_ack();
    wait_req(60);
    for (int i = 0; i < 100; i++) begin
      tog = ~tog;
      bus.frame_tick = tog;
      @(negedge clk);
      checks++;
      if (bus.spawn_req !== 1'b1 || bus.enemies_remaining !== 5'd8) begin
        fails++;
        $display("FAIL bp_hold%0d: got req=%0b rem=%0d, want 1/8",
                 i, bus.spawn_req, bus.enemies_remaining);
      end
    end
    bus.frame_tick = 1'b0;
    do_ack();
    wait_req(60);
  endtask

  task automatic test_simultaneous();
    bus.enemy_killed  = 1'b1;
    bus.enemy_escaped = 1'b1;
    bus.spawn_ack     = 1'b1;
    @(negedge clk);
    bus.enemy_killed  = 1'b0;
    bus.enemy_escaped = 1'b0;
    bus.spawn_ack     = 1'b0;
    checks++;
    if (bus.enemies_remaining !== 5'd6 || bus.lives !== 3'd4) begin
      fails++;
      $display("FAIL simul: got rem=%0d lives=%0d, want 6/4",
               bus.enemies_remaining, bus.lives);
    end
    checks++;
    if (bus.spawn_req !== 1'b0) begin
      fails++;
      $display("FAIL simul_req: got %0b, want 0", bus.spawn_req);
    end
    bus.stage_1_in_progress = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.enemies_remaining !== 5'd0 || bus.lives !== 3'd4) begin
      fails++;
      $display("FAIL simul_abort: got rem=%0d lives=%0d, want 0/4",
               bus.enemies_remaining, bus.lives);
    end
  endtask

  task automatic test_abort_restart();
    bus.stage_3_in_progress = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.enemies_remaining !== 5'd16) begin
      fails++;
      $display("FAIL ab_load: got rem=%0d, want 16",
               bus.enemies_remaining);
    end
    @(negedge clk);
    checks++;
    if (bus.spawn_req !== 1'b1 || bus.spawn_stage !== 2'd3) begin
      fails++;
      $display("FAIL ab_req: got req=%0b stage=%0d, want 1/3",
               bus.spawn_req, bus.spawn_stage);
    end
    do_ack();
    for (int i = 0; i < 10; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    bus.stage_3_in_progress = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.enemies_remaining !== 5'd0 || bus.spawn_req !== 1'b0
        || bus.lives !== 3'd4) begin
      fails++;
      $display("FAIL ab_idle: got rem=%0d req=%0b lives=%0d, want 0/0/4",
               bus.enemies_remaining, bus.spawn_req, bus.lives);
    end
    bus.stage_3_in_progress = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.enemies_remaining !== 5'd16) begin
      fails++;
      $display("FAIL ab_reload: got rem=%0d, want 16",
               bus.enemies_remaining);
    end
    @(negedge clk);
    checks++;
    if (bus.spawn_stage !== 2'd3 || bus.lives !== 3'd4) begin
      fails++;
      $display("FAIL ab_rereq: got stage=%0d lives=%0d, want 3/4",
               bus.spawn_stage, bus.lives);
    end
  endtask

  task automatic test_reset_midwave();
    do_ack();
    repeat (5) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    bus.stage_3_in_progress = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.spawn_req !== 1'b0 || bus.spawn_stage !== 2'd0
        || bus.enemies_remaining !== 5'd0 || bus.lives !== 3'd5) begin
      fails++;
      $display("FAIL rst_mid: got req=%0b st=%0d rem=%0d lives=%0d, want 0/0/0/5",
               bus.spawn_req, bus.spawn_stage,
               bus.enemies_remaining, bus.lives);
    end
    checks++;
    if ({bus.stage_1_done, bus.stage_2_done, bus.stage_3_done,
         bus.game_over} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_mid_flags: got %b, want 0000",
               {bus.stage_1_done, bus.stage_2_done,
                bus.stage_3_done, bus.game_over});
    end
  endtask

  task automatic test_game_over();
    bus.stage_2_in_progress = 1'b1;
    bus.stage_3_in_progress = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.enemies_remaining !== 5'd12) begin
      fails++;
      $display("FAIL go_load: got rem=%0d, want 12",
               bus.enemies_remaining);
    end
    @(negedge clk);
    checks++;
    if (bus.spawn_stage !== 2'd2) begin
      fails++;
      $display("FAIL go_prio: got stage=%0d, want 2", bus.spawn_stage);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_req(60);
      do_ack();
      pulse(1'b0, 1'b1);
      checks++;
      if (bus.lives !== 3'(4 - i)) begin
        fails++;
        $display("FAIL go_lives%0d: got %0d, want %0d",
                 i, bus.lives, 4 - i);
      end
    end
    checks++;
    if (bus.game_over !== 1'b0) begin
      fails++;
      $display("FAIL go_early: got %0b, want 0", bus.game_over);
    end
    @(negedge clk);
    checks++;
    if (bus.game_over !== 1'b1 || bus.stage_2_done !== 1'b0) begin
      fails++;
      $display("FAIL go_dead: got go=%0b done2=%0b, want 1/0",
               bus.game_over, bus.stage_2_done);
    end
    bus.stage_2_in_progress = 1'b0;
    bus.stage_3_in_progress = 1'b0;
    pulse(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.game_over !== 1'b1 || bus.lives !== 3'd0
        || bus.spawn_req !== 1'b0 || bus.stage_2_done !== 1'b0) begin
      fails++;
      $display("FAIL go_sticky: got go=%0b lives=%0d req=%0b d2=%0b, want 1/0/0/0",
               bus.game_over, bus.lives, bus.spawn_req, bus.stage_2_done);
    end
  endtask

  initial begin
    bus.stage_1_in_progress = 1'b0;
    bus.stage_2_in_progress = 1'b0;
    bus.stage_3_in_progress = 1'b0;
    bus.frame_tick          = 1'b0;
    bus.spawn_ack           = 1'b0;
    bus.enemy_killed        = 1'b0;
    bus.enemy_escaped       = 1'b0;
    test_reset();
    test_stage1();
    test_backpressure();
    test_simultaneous();
    test_abort_restart();
    test_reset_midwave();
    test_game_over();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/wave_manager.md
Name: wave_manager

Overview:
Drives enemy waves for each stage and judges each stage's outcome for the game-flow controller. Reads the one-hot stage_N_in_progress outputs of the flow FSM and issues spawn requests to the enemy engine. Counts kills and escapes and tracks player lives. Produces the stage_N_done and game_over feedback that the flow FSM consumes in its IN_PROGRESS states.

Parameters:
S1_ENEMIES, 8, enemies spawned in stage 1
S2_ENEMIES, 12, enemies spawned in stage 2
S3_ENEMIES, 16, enemies spawned in stage 3
SPAWN_INTERVAL, 60, frame_ticks between an accepted spawn and the next request (1..255)
START_LIVES, 5, lives at reset (1..7)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stage_1_in_progress  in  1  flow FSM is in stage 1 play state
stage_2_in_progress  in  1  flow FSM is in stage 2 play state
stage_3_in_progress  in  1  flow FSM is in stage 3 play state
frame_tick  in  1  one-cycle pulse per video frame
spawn_ack  in  1  enemy engine accepted the current spawn request
enemy_killed  in  1  one-cycle pulse: an alive enemy was destroyed
enemy_escaped  in  1  one-cycle pulse: an alive enemy reached the base
spawn_req  out  1  request for one enemy to spawn
spawn_stage  out  2  stage index of the request (1..3), valid while spawn_req is high
enemies_remaining  out  5  enemies not yet spawned plus enemies alive
lives  out  3  current lives
stage_1_done  out  1  stage 1 cleared (level)
stage_2_done  out  1  stage 2 cleared (level)
stage_3_done  out  1  stage 3 cleared (level)
game_over  out  1  lives exhausted (sticky)

Behaviour:
- Reset values:
  - state IDLE; spawn_req 0, spawn_stage 0, enemies_remaining 0.
  - lives START_LIVES; all done outputs 0; game_over 0.
  - spawn_left 0, alive 0, interval counter 0.
- Stage select: when more than one in_progress input is high, the lowest-numbered stage wins.
- IDLE:
  - On any in_progress high, go to LOAD.
  - Latch stage index and set spawn_left to S{n}_ENEMIES.
  - Clear alive and the interval counter.
- LOAD: always moves to REQ on the next cycle (one-cycle gap).
- REQ:
  - spawn_req=1 and spawn_stage=latched index, both held until spawn_ack.
  - Cycle with spawn_ack: spawn_left-1, alive+1, counter cleared.
  - Next state is WAIT if spawn_left was above 1 before the ack, otherwise DRAIN.
  - spawn_req falls the cycle after the ack.
- WAIT: counter increments on each frame_tick. The tick that brings it to SPAWN_INTERVAL moves to REQ, so the request rises SPAWN_INTERVAL ticks after the ack.
- DRAIN: when alive==0, move to DONE.
- DONE:
  - stage_N_done=1 for the latched stage only.
  - Hold until all in_progress inputs are low, then go to IDLE.
- DEAD: game_over=1. Only reset leaves this state.
- Kill/escape, active in LOAD, REQ, WAIT and DRAIN:
  - alive decrements once per asserted pulse; kill and escape in the same cycle give -2.
  - alive saturates at 0; pulses arriving with alive 0 are ignored.
  - spawn_ack in the same cycle adds +1 to the net change.
  - Each escape counted against a non-zero alive decrements lives.
  - When lives reaches 0, go to DEAD next cycle. DEAD has priority over DONE and over the REQ/WAIT transitions.
- enemies_remaining = spawn_left + alive, registered, updated the same cycle as the counters.
- Lives carry across stages and are restored only by reset.
- Abort: in_progress dropping in LOAD/REQ/WAIT/DRAIN returns to IDLE and clears spawn_left and alive. Lives are kept.
- Pulses received in IDLE, DONE or DEAD are ignored.

Optional Feature:
BONUS_LIFE_EN:
- Defined: on entry to DONE, lives increments by 1, saturating at START_LIVES.
- Undefined: lives never increases after reset.

Test Plan:
- Stage 1 normal:
  - Stimulus: stage_1_in_progress high, ack every request, 8 kills after the last spawn.
  - Required: 8 requests, each rising exactly 60 ticks after the previous ack; stage_1_done=1; lives=5.
- Spawn backpressure: hold spawn_ack low for 100 cycles.
  - Required: spawn_req stays high; spawn_left, alive and enemies_remaining unchanged.
- Game over: 5 escapes during stage 2 with START_LIVES=5.
  - Required: lives counts 4,3,2,1,0, then game_over=1 the next cycle; stage_2_done stays 0; game_over holds after in_progress drops.
- Simultaneous events: alive=2, then kill, escape and spawn_ack in the same cycle.
  - Required: alive=1, lives decremented by 1, enemies_remaining updated in that cycle.
- Abort then restart:
  - Stimulus: drop stage_3_in_progress mid-wave, re-raise it.
  - Required: IDLE entered; new wave loads 16 enemies; lives unchanged.
- Reset mid-wave: assert reset for 1 cycle during WAIT.
  - Required: all outputs at reset values the next cycle; lives=5.
